// File: rtl/mem_port_arbiter_pkg.sv
// Shared definitions for the IF/DM unified-memory arbiter: FSM encodings,
// requester IDs and a counter-width helper.
package mem_port_arbiter_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'b00,
        ISSUE = 2'b01,
        WAIT  = 2'b10,
        RESP  = 2'b11
    } state_t;

    typedef enum logic {
        GNT_IF = 1'b0,
        GNT_DM = 1'b1
    } gnt_t;

    // Bits needed to hold the values 0..v (never less than one bit).
    function automatic int cnt_width(input int v);
        return (v < 1) ? 1 : $clog2(v + 1);
    endfunction

endpackage

// File: rtl/mem_port_arbiter_if.sv
// Requester and memory-side signal bundle of the arbiter. The slave modport
// is the arbiter; the master modport is the pipeline plus memory.
interface mem_port_arbiter_if;
    logic        if_req;
    logic [31:0] if_addr;
    logic        if_cancel;
    logic [31:0] if_rdata;
    logic        if_ready;

    logic        dm_req;
    logic        dm_we;
    logic [31:0] dm_addr;
    logic [31:0] dm_wdata;
    logic [31:0] dm_rdata;
    logic        dm_ready;

    logic        mem_en;
    logic        mem_we;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [31:0] mem_rdata;

    logic        busy;

    modport slave (
        input  if_req, if_addr, if_cancel,
        input  dm_req, dm_we, dm_addr, dm_wdata,
        input  mem_rdata,
        output if_rdata, if_ready, dm_rdata, dm_ready,
        output mem_en, mem_we, mem_addr, mem_wdata, busy
    );

    modport master (
        output if_req, if_addr, if_cancel,
        output dm_req, dm_we, dm_addr, dm_wdata,
        output mem_rdata,
        input  if_rdata, if_ready, dm_rdata, dm_ready,
        input  mem_en, mem_we, mem_addr, mem_wdata, busy
    );
endinterface

// File: rtl/mem_port_arbiter_pick.sv
// Winner selection between IF and DM, with a saturating count of DM grants
// made while IF was kept waiting.
module mem_arb_pick
    import mem_port_arbiter_pkg::*;
#(
    parameter int STARVE_MAX = 4
) (
    input  logic clk,
    input  logic rst_n,
    input  logic if_cand,
    input  logic dm_cand,
    input  logic grant_en,
    output logic win_valid,
    output gnt_t win_id
);
    localparam int SW = cnt_width(STARVE_MAX);
    localparam logic [SW-1:0] STARVE_LIM = SW'(STARVE_MAX);

    logic [SW-1:0] starve_cnt_q;
    logic [SW-1:0] starve_cnt_d;

    always_comb begin
        win_valid    = if_cand | dm_cand;
        win_id       = GNT_IF;
        starve_cnt_d = starve_cnt_q;

        // DM has priority unless IF has already been passed over STARVE_MAX times.
        if (dm_cand && !(if_cand && (starve_cnt_q == STARVE_LIM))) begin
            win_id = GNT_DM;
        end

        if (grant_en && win_valid) begin
            if (win_id == GNT_IF) begin
                starve_cnt_d = '0;
            end else if (if_cand) begin
                starve_cnt_d = (starve_cnt_q == STARVE_LIM) ? starve_cnt_q
                                                            : starve_cnt_q + SW'(1);
            end else begin
                starve_cnt_d = '0;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            starve_cnt_q <= '0;
        end else begin
            starve_cnt_q <= starve_cnt_d;
        end
    end

endmodule

// File: rtl/mem_port_arbiter.sv
// Arbitrates a single-port fixed-latency memory between instruction fetch and
// data memory: grant, issue, latency wait, then a one-cycle ready pulse.
module mem_port_arbiter
    import mem_port_arbiter_pkg::*;
#(
    parameter int LATENCY    = 2,
    parameter int STARVE_MAX = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    mem_port_arbiter_if.slave bus
);
    localparam int CW = cnt_width(LATENCY - 1);

    state_t        state_q,     state_d;
    gnt_t          gnt_q,       gnt_d;
    logic [CW-1:0] cnt_q,       cnt_d;
    logic          cancel_q,    cancel_d;
    logic          mem_en_q,    mem_en_d;
    logic          mem_we_q,    mem_we_d;
    logic [31:0]   mem_addr_q,  mem_addr_d;
    logic [31:0]   mem_wdata_q, mem_wdata_d;
    logic [31:0]   if_rdata_q,  if_rdata_d;
    logic [31:0]   dm_rdata_q,  dm_rdata_d;
    logic          if_ready_q,  if_ready_d;
    logic          dm_ready_q,  dm_ready_d;
    logic          busy_q,      busy_d;

    logic if_cand;
    logic dm_cand;
    logic win_valid;
    gnt_t win_id;

    assign if_cand = bus.if_req & ~bus.if_cancel;
    assign dm_cand = bus.dm_req;

    mem_arb_pick #(
        .STARVE_MAX (STARVE_MAX)
    ) u_pick (
        .clk       (clk),
        .rst_n     (rst_n),
        .if_cand   (if_cand),
        .dm_cand   (dm_cand),
        .grant_en  (state_q == IDLE),
        .win_valid (win_valid),
        .win_id    (win_id)
    );

    always_comb begin
        state_d     = state_q;
        gnt_d       = gnt_q;
        cnt_d       = cnt_q;
        cancel_d    = cancel_q;
        mem_en_d    = 1'b0;
        mem_we_d    = mem_we_q;
        mem_addr_d  = mem_addr_q;
        mem_wdata_d = mem_wdata_q;
        if_rdata_d  = if_rdata_q;
        dm_rdata_d  = dm_rdata_q;
        if_ready_d  = 1'b0;
        dm_ready_d  = 1'b0;

        if ((state_q != IDLE) && (gnt_q == GNT_IF) && bus.if_cancel) begin
            cancel_d = 1'b1;
        end

        case (state_q)
            IDLE: begin
                if (win_valid) begin
                    gnt_d    = win_id;
                    state_d  = ISSUE;
                    mem_en_d = 1'b1;
                    if (win_id == GNT_DM) begin
                        mem_we_d    = bus.dm_we;
                        mem_addr_d  = bus.dm_addr;
                        mem_wdata_d = bus.dm_wdata;
                    end else begin
                        mem_we_d   = 1'b0;
                        mem_addr_d = bus.if_addr;
                    end
                end
            end
            ISSUE: begin
                cnt_d = CW'(LATENCY - 1);
                if (mem_we_q) begin
                    state_d    = RESP;
                    dm_ready_d = (gnt_q == GNT_DM);
                    if_ready_d = (gnt_q == GNT_IF) && !cancel_d;
                end else begin
                    state_d = WAIT;
                end
            end
            WAIT: begin
                if (cnt_q == '0) begin
                    state_d = RESP;
                    // A cancelled fetch still lands its data; only the ready is withheld.
                    if (gnt_q == GNT_DM) begin
                        dm_rdata_d = bus.mem_rdata;
                        dm_ready_d = 1'b1;
                    end else begin
                        if_rdata_d = bus.mem_rdata;
                        if_ready_d = !cancel_d;
                    end
                end else begin
                    cnt_d = cnt_q - CW'(1);
                end
            end
            RESP: begin
                state_d  = IDLE;
                cancel_d = 1'b0;
            end
            default: state_d = IDLE;
        endcase

        busy_d = (state_d != IDLE);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            gnt_q       <= GNT_IF;
            cnt_q       <= '0;
            cancel_q    <= 1'b0;
            mem_en_q    <= 1'b0;
            mem_we_q    <= 1'b0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
            if_rdata_q  <= '0;
            dm_rdata_q  <= '0;
            if_ready_q  <= 1'b0;
            dm_ready_q  <= 1'b0;
            busy_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            gnt_q       <= gnt_d;
            cnt_q       <= cnt_d;
            cancel_q    <= cancel_d;
            mem_en_q    <= mem_en_d;
            mem_we_q    <= mem_we_d;
            mem_addr_q  <= mem_addr_d;
            mem_wdata_q <= mem_wdata_d;
            if_rdata_q  <= if_rdata_d;
            dm_rdata_q  <= dm_rdata_d;
            if_ready_q  <= if_ready_d;
            dm_ready_q  <= dm_ready_d;
            busy_q      <= busy_d;
        end
    end

    assign bus.mem_en    = mem_en_q;
    assign bus.mem_we    = mem_we_q;
    assign bus.mem_addr  = mem_addr_q;
    assign bus.mem_wdata = mem_wdata_q;
    assign bus.if_rdata  = if_rdata_q;
    assign bus.dm_rdata  = dm_rdata_q;
    assign bus.if_ready  = if_ready_q;
    assign bus.dm_ready  = dm_ready_q;
    assign bus.busy      = busy_q;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter: a table of single transactions plus
// hand-written sequences for contention, starvation, cancel and reset.
module tb_mem_port_arbiter;
    localparam int LAT = 2;
    localparam logic [31:0] KEY = 32'h2002_0015;

    typedef struct {
        logic        is_dm;
        logic        we;
        logic [31:0] addr;
        logic [31:0] wdata;
        int          exp_rdy;
        logic [31:0] exp_rdata;
    } vec_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   n_checks = 0;
    int   n_errors = 0;
    logic [31:0] exp_if = '0;
    logic [31:0] exp_dm = '0;

    mem_port_arbiter_if bus ();

    mem_port_arbiter #(
        .LATENCY    (LAT),
        .STARVE_MAX (4)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    // Memory returns addr ^ KEY exactly LAT cycles after mem_en, junk otherwise.
    logic        v_pipe [LAT];
    logic [31:0] a_pipe [LAT];
    initial for (int i = 0; i < LAT; i++) begin v_pipe[i] = 1'b0; a_pipe[i] = '0; end
    always @(posedge clk) begin
        v_pipe[0] <= bus.mem_en;
        a_pipe[0] <= bus.mem_addr;
        for (int i = 1; i < LAT; i++) begin
            v_pipe[i] <= v_pipe[i-1];
            a_pipe[i] <= a_pipe[i-1];
        end
    end
    assign bus.mem_rdata = v_pipe[LAT-1] ? (a_pipe[LAT-1] ^ KEY) : 32'hBAD0_BAD0;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic run_txn(input vec_t v, input string nm);
        int en_cnt = 0, en_cyc = -1, rdy_cyc = -1, rdy_cnt = 0, oth_rdy = 0;
        logic [31:0] a_seen = '0, wd_seen = '0;
        logic we_seen = 1'b0, busy_after = 1'b1;
        logic [31:0] oth_before;
        oth_before = v.is_dm ? exp_if : exp_dm;
        if (v.is_dm) begin
            bus.dm_req = 1'b1; bus.dm_we = v.we; bus.dm_addr = v.addr; bus.dm_wdata = v.wdata;
        end else begin
            bus.if_req = 1'b1; bus.if_addr = v.addr;
        end
        for (int c = 1; c <= 12; c++) begin
            tick();
            if (bus.mem_en) begin
                en_cnt++; en_cyc = c; a_seen = bus.mem_addr;
                we_seen = bus.mem_we; wd_seen = bus.mem_wdata;
            end
            if ((v.is_dm ? bus.dm_ready : bus.if_ready) === 1'b1) begin
                rdy_cnt++; rdy_cyc = c;
            end
            if ((v.is_dm ? bus.if_ready : bus.dm_ready) === 1'b1) oth_rdy++;
            if (c == v.exp_rdy + 1) busy_after = bus.busy;
            if (rdy_cyc > 0 && c == rdy_cyc + 1) begin
                bus.dm_req = 1'b0; bus.if_req = 1'b0;
            end
        end
        bus.dm_req = 1'b0; bus.if_req = 1'b0;
        chk({nm, " mem_en count"}, en_cnt, 1);
        chk({nm, " mem_en cycle"}, en_cyc, 1);
        chk({nm, " mem_addr"}, a_seen, v.addr);
        chk({nm, " mem_we"}, {31'b0, we_seen}, {31'b0, v.we});
        if (v.we) chk({nm, " mem_wdata"}, wd_seen, v.wdata);
        chk({nm, " ready cycle"}, rdy_cyc, v.exp_rdy);
        chk({nm, " ready pulses"}, rdy_cnt, 1);
        chk({nm, " other ready pulses"}, oth_rdy, 0);
        chk({nm, " busy after resp"}, {31'b0, busy_after}, 32'd0);
        chk({nm, " rdata"}, v.is_dm ? bus.dm_rdata : bus.if_rdata, v.exp_rdata);
        chk({nm, " other rdata"}, v.is_dm ? bus.if_rdata : bus.dm_rdata, oth_before);
        if (v.is_dm) exp_dm = v.exp_rdata; else exp_if = v.exp_rdata;
        $display("txn %s: dm=%0b we=%0b addr=%h ready_cyc=%0d rdata=%h", nm, v.is_dm, v.we,
                 v.addr, rdy_cyc, v.is_dm ? bus.dm_rdata : bus.if_rdata);
    endtask

    vec_t vecs [5];

    initial begin
        int en_n, en_c [6], dm_rc, if_rc, if_pulses;
        logic [31:0] en_a [6];
        logic [31:0] st_at [6];
        logic busy5;

        vecs[0] = '{1'b0, 1'b0, 32'h0000_0010, 32'h0,         4, 32'h2002_0005};
        vecs[1] = '{1'b1, 1'b0, 32'h0000_0100, 32'h0,         4, 32'h2002_0115};
        vecs[2] = '{1'b1, 1'b1, 32'h0000_0200, 32'hDEAD_BEEF, 2, 32'h2002_0115};
        vecs[3] = '{1'b0, 1'b0, 32'h0000_0013, 32'h0,         4, 32'h2002_0006};
        vecs[4] = '{1'b1, 1'b0, 32'hFFFF_FFFC, 32'h0,         4, 32'hDFFD_FFE9};

        bus.if_req = 1'b0; bus.if_addr = '0; bus.if_cancel = 1'b0;
        bus.dm_req = 1'b0; bus.dm_we = 1'b0; bus.dm_addr = '0; bus.dm_wdata = '0;

        // Reset state
        #3;
        chk("reset mem_en", {31'b0, bus.mem_en}, 32'd0);
        tick(); tick();
        chk("reset busy", {31'b0, bus.busy}, 32'd0);
        chk("reset ready", {30'b0, bus.if_ready, bus.dm_ready}, 32'd0);
        chk("reset mem_addr", bus.mem_addr, 32'd0);
        chk("reset rdata", bus.if_rdata | bus.dm_rdata, 32'd0);
        rst_n = 1'b1;
        tick();
        $display("reset released");

        for (int i = 0; i < 5; i++) run_txn(vecs[i], $sformatf("vec%0d", i));

        // Simultaneous IF and DM: DM first, IF after one IDLE cycle
        bus.if_req = 1'b1; bus.if_addr = 32'h14;
        bus.dm_req = 1'b1; bus.dm_we = 1'b0; bus.dm_addr = 32'h100;
        en_n = 0; dm_rc = -1; if_rc = -1; busy5 = 1'b1;
        for (int c = 1; c <= 14; c++) begin
            tick();
            if (dm_rc == c - 1) bus.dm_req = 1'b0;
            if (if_rc == c - 1) bus.if_req = 1'b0;
            if (bus.mem_en && en_n < 2) begin en_c[en_n] = c; en_a[en_n] = bus.mem_addr; en_n++; end
            if (bus.dm_ready) dm_rc = c;
            if (bus.if_ready) if_rc = c;
            if (c == 5) busy5 = bus.busy;
        end
        chk("both first grant cycle", en_c[0], 1);
        chk("both first grant addr", en_a[0], 32'h100);
        chk("both dm_ready cycle", dm_rc, 4);
        chk("both busy gap", {31'b0, busy5}, 32'd0);
        chk("both second grant cycle", en_c[1], 6);
        chk("both second grant addr", en_a[1], 32'h14);
        chk("both if_ready cycle", if_rc, 9);
        chk("both dm_rdata", bus.dm_rdata, 32'h2002_0115);
        chk("both if_rdata", bus.if_rdata, 32'h2002_0001);
        $display("txn both: dm_ready=%0d if_ready=%0d", dm_rc, if_rc);

        // Starvation: four DM grants while IF waits, then IF is forced through
        bus.if_req = 1'b1; bus.if_addr = 32'h500;
        bus.dm_req = 1'b1; bus.dm_we = 1'b0; bus.dm_addr = 32'h300;
        en_n = 0; dm_rc = -1; if_rc = -1;
        for (int c = 1; c <= 45; c++) begin
            tick();
            if (dm_rc == c - 1) begin
                if (bus.dm_addr == 32'h310) bus.dm_req = 1'b0;
                else bus.dm_addr = bus.dm_addr + 32'd4;
            end
            if (if_rc == c - 1) bus.if_req = 1'b0;
            if (bus.mem_en && en_n < 6) begin
                en_a[en_n] = bus.mem_addr;
                st_at[en_n] = 32'(dut.u_pick.starve_cnt_q);
                en_n++;
            end
            if (bus.dm_ready) dm_rc = c;
            if (bus.if_ready) if_rc = c;
        end
        bus.if_req = 1'b0; bus.dm_req = 1'b0;
        chk("starve grants", en_n, 6);
        for (int g = 0; g < 6; g++) begin
            logic [31:0] ea, es;
            ea = (g < 4) ? 32'h300 + 32'(4 * g) : (g == 4) ? 32'h500 : 32'h310;
            es = (g < 4) ? 32'(g + 1) : 32'd0;
            chk($sformatf("starve grant%0d addr", g), en_a[g], ea);
            chk($sformatf("starve grant%0d cnt", g), st_at[g], es);
        end
        $display("txn starve: grants=%0d fifth=%h", en_n, en_a[4]);
        exp_if = 32'h500 ^ KEY; exp_dm = 32'h310 ^ KEY;

        // Cancel during WAIT of an IF read, then a DM read
        tick();
        bus.if_req = 1'b1; bus.if_addr = 32'h20;
        en_n = 0; dm_rc = -1; if_pulses = 0; busy5 = 1'b1;
        for (int c = 1; c <= 14; c++) begin
            tick();
            if (c == 2) bus.if_cancel = 1'b1;
            if (c == 3) begin bus.if_cancel = 1'b0; bus.if_req = 1'b0; end
            if (c == 5) begin
                busy5 = bus.busy;
                bus.dm_req = 1'b1; bus.dm_we = 1'b0; bus.dm_addr = 32'h400;
            end
            if (dm_rc == c - 1) bus.dm_req = 1'b0;
            if (bus.mem_en && en_n < 2) begin en_c[en_n] = c; en_a[en_n] = bus.mem_addr; en_n++; end
            if (bus.if_ready) if_pulses++;
            if (bus.dm_ready) dm_rc = c;
        end
        bus.dm_req = 1'b0;
        chk("cancel mem_en cycle", en_c[0], 1);
        chk("cancel if_ready pulses", if_pulses, 0);
        chk("cancel if_rdata", bus.if_rdata, 32'h2002_0035);
        chk("cancel idle", {31'b0, busy5}, 32'd0);
        chk("cancel dm addr", en_a[1], 32'h400);
        chk("cancel dm_ready cycle", dm_rc, 9);
        chk("cancel dm_rdata", bus.dm_rdata, 32'h2002_0415);
        $display("txn cancel: if_pulses=%0d dm_ready=%0d", if_pulses, dm_rc);

        // Asynchronous reset in the middle of a DM read
        tick();
        bus.dm_req = 1'b1; bus.dm_we = 1'b0; bus.dm_addr = 32'h600;
        tick(); tick();
        #2;
        rst_n = 1'b0;
        #1;
        chk("rst mid mem_en", {31'b0, bus.mem_en}, 32'd0);
        chk("rst mid dm_ready", {31'b0, bus.dm_ready}, 32'd0);
        chk("rst mid busy", {31'b0, bus.busy}, 32'd0);
        chk("rst mid dm_rdata", bus.dm_rdata, 32'd0);
        chk("rst mid if_rdata", bus.if_rdata, 32'd0);
        chk("rst mid mem_addr", bus.mem_addr, 32'd0);
        bus.dm_req = 1'b0;
        tick(); tick();
        rst_n = 1'b1;
        exp_if = '0; exp_dm = '0;
        $display("txn reset: mid-read reset applied and released");
        run_txn('{1'b0, 1'b0, 32'h44, 32'h0, 4, 32'h2002_0051}, "post_rst");

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
